// File: rtl/pong_game_ctrl.sv
// PONG game sequencer: game FSM, score/lives bookkeeping, frame timing and
// ball/paddle movement strobes. Every output comes straight from a flop.
module pong_game_ctrl #(
  parameter int LIVES_INIT       = 3,
  parameter int SCORE_W          = 10,
  parameter int SERVE_FRAMES     = 60,
  parameter int MISS_FRAMES      = 30,
  parameter int OVER_FRAMES      = 180,
  parameter int BALL_PERIOD_INIT = 20000,
  parameter int BALL_PERIOD_STEP = 2000,
  parameter int BALL_PERIOD_MIN  = 6000,
  parameter int SPEED_STEP       = 8,
  parameter int PADDLE_PERIOD    = 15000
) (
  input  logic               vga_clock_i,
  input  logic               reset_i,
  input  logic               end_of_frame_i,
  input  logic               button_left_i,
  input  logic               button_right_i,
  input  logic               hit_paddle_i,
  input  logic               miss_i,
  output logic               run_o,
  output logic               ball_reset_o,
  output logic               ball_tick_o,
  output logic               paddle_tick_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [2:0]         lives_o,
  output logic               game_over_o,
  output logic [2:0]         state_o
);

  localparam int PW   = $clog2(BALL_PERIOD_INIT + 1);
  localparam int DW   = $clog2(PADDLE_PERIOD + 1);
  localparam int FMX0 = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int FMAX = (FMX0 > OVER_FRAMES) ? FMX0 : OVER_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam int SW   = $clog2(SPEED_STEP + 1);

  localparam logic [PW-1:0]      P_INIT    = PW'(BALL_PERIOD_INIT);
  localparam logic [PW-1:0]      P_STEP    = PW'(BALL_PERIOD_STEP);
  localparam logic [PW-1:0]      P_MIN     = PW'(BALL_PERIOD_MIN);
  localparam logic [PW-1:0]      P_FLOOR   = PW'(BALL_PERIOD_MIN + BALL_PERIOD_STEP);
  localparam logic [DW-1:0]      PAD_LAST  = DW'(PADDLE_PERIOD - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RUN   = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [FW-1:0]        frame_q, frame_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           lives_q, lives_d;
  logic [PW-1:0]        period_q, period_d;
  logic [SW-1:0]        step_q, step_d;
  logic [PW-1:0]        ball_cnt_q, ball_cnt_d;
  logic [PW-1:0]        ball_lim_q, ball_lim_d;
  logic [DW-1:0]        pad_cnt_q, pad_cnt_d;
  logic                 ball_tick_q, ball_tick_d;
  logic                 pad_tick_q, pad_tick_d;
  logic                 run_q, ball_reset_q, game_over_q;
  logic                 btn_x_q, press_q;
  logic                 btn_x, run_stay, pad_stay, ball_wrap, pad_wrap;

  assign btn_x = button_left_i ^ button_right_i;

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    lives_d  = lives_q;
    period_d = period_q;
    step_d   = step_q;
    case (state_q)
      IDLE: if (press_q) begin
        state_d  = SERVE;
        score_d  = '0;
        lives_d  = 3'(LIVES_INIT);
        period_d = P_INIT;
        step_d   = '0;
      end
      SERVE: if (end_of_frame_i && frame_q == FW'(SERVE_FRAMES - 1)) state_d = RUN;
      RUN: begin
        // A miss pre-empts a same-cycle paddle hit.
        if (miss_i) begin
          lives_d = lives_q - 3'd1;
          state_d = (lives_q == 3'd1) ? OVER : MISS;
        end else if (hit_paddle_i && score_q != SCORE_MAX) begin
          score_d = score_q + SCORE_W'(1);
          if (step_q == SW'(SPEED_STEP - 1)) begin
            step_d   = '0;
            period_d = (period_q >= P_FLOOR) ? period_q - P_STEP : P_MIN;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      MISS: if (end_of_frame_i && frame_q == FW'(MISS_FRAMES - 1)) state_d = SERVE;
      OVER: if (end_of_frame_i && frame_q == FW'(OVER_FRAMES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    frame_d = frame_q;
    if (state_d != state_q) frame_d = '0;
    else if (end_of_frame_i && (state_q == SERVE || state_q == MISS || state_q == OVER))
      frame_d = frame_q + FW'(1);

    // Ball limit is latched at each wrap so a speed-up lands on the next interval.
    run_stay    = (state_q == RUN) && (state_d == RUN);
    ball_wrap   = (ball_cnt_q == ball_lim_q - PW'(1));
    ball_cnt_d  = (run_stay && !ball_wrap) ? ball_cnt_q + PW'(1) : '0;
    ball_tick_d = run_stay && ball_wrap;
    ball_lim_d  = (!run_stay || ball_wrap) ? period_q : ball_lim_q;

    pad_stay   = (state_q == SERVE || state_q == RUN) && (state_d == SERVE || state_d == RUN);
    pad_wrap   = (pad_cnt_q == PAD_LAST);
    pad_cnt_d  = (pad_stay && !pad_wrap) ? pad_cnt_q + DW'(1) : '0;
    pad_tick_d = pad_stay && pad_wrap;
  end

  always_ff @(posedge vga_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      score_q      <= '0;
      lives_q      <= 3'(LIVES_INIT);
      period_q     <= P_INIT;
      step_q       <= '0;
      ball_cnt_q   <= '0;
      ball_lim_q   <= P_INIT;
      pad_cnt_q    <= '0;
      ball_tick_q  <= 1'b0;
      pad_tick_q   <= 1'b0;
      run_q        <= 1'b0;
      ball_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
      btn_x_q      <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      period_q     <= period_d;
      step_q       <= step_d;
      ball_cnt_q   <= ball_cnt_d;
      ball_lim_q   <= ball_lim_d;
      pad_cnt_q    <= pad_cnt_d;
      ball_tick_q  <= ball_tick_d;
      pad_tick_q   <= pad_tick_d;
      run_q        <= (state_d == RUN);
      ball_reset_q <= (state_d != RUN);
      game_over_q  <= (state_d == OVER);
      btn_x_q      <= btn_x;
      press_q      <= btn_x & ~btn_x_q;
    end
  end

  assign run_o         = run_q;
  assign ball_reset_o  = ball_reset_q;
  assign ball_tick_o   = ball_tick_q;
  assign paddle_tick_o = pad_tick_q;
  assign score_o       = score_q;
  assign lives_o       = lives_q;
  assign game_over_o   = game_over_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: timestamp-based game model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_pong_game_ctrl;
  localparam int LIVES = 3;
  localparam int SMAX  = 1023;
  localparam int PINIT = 20000;
  localparam int PSTEP = 2000;
  localparam int PMIN  = 6000;
  localparam int PADP  = 15000;

  logic clk = 1'b0, rst = 1'b1, eof = 1'b0, bl = 1'b0, br = 1'b0, hit = 1'b0, miss = 1'b0;
  logic run, ball_reset, ball_tick, paddle_tick, game_over;
  logic [9:0] score;
  logic [2:0] lives, state;
  int cyc = 0;
  int tests = 0, fails = 0;

  pong_game_ctrl dut (
    .vga_clock_i(clk), .reset_i(rst), .end_of_frame_i(eof),
    .button_left_i(bl), .button_right_i(br), .hit_paddle_i(hit), .miss_i(miss),
    .run_o(run), .ball_reset_o(ball_reset), .ball_tick_o(ball_tick),
    .paddle_tick_o(paddle_tick), .score_o(score), .lives_o(lives),
    .game_over_o(game_over), .state_o(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Game model: states by spec code, tick times as absolute edge stamps.
  int m_t, m_state, m_score, m_lives, m_period, m_frames;
  int m_ball_next, m_pad_next;
  bit m_press, m_x, e_bt, e_pt;

  task automatic m_reset();
    m_state = 0; m_score = 0; m_lives = LIVES; m_period = PINIT; m_frames = 0;
    m_press = 0; m_x = 0; e_bt = 0; e_pt = 0;
  endtask

  function automatic bit active(input int s);
    return s == 1 || s == 2;
  endfunction

  task automatic m_step();
    int s, ns, old_p;
    bit use_press, x;
    m_t++;
    x = bl ^ br;
    use_press = m_press;
    m_press = x && !m_x;
    m_x = x;
    s = m_state; ns = s; old_p = m_period;
    case (s)
      0: if (use_press) begin ns = 1; m_score = 0; m_lives = LIVES; m_period = PINIT; end
      1: if (eof) begin m_frames++; if (m_frames == 60) ns = 2; end
      2: if (miss) begin
           m_lives--;
           ns = (m_lives == 0) ? 4 : 3;
         end else if (hit && m_score < SMAX) begin
           m_score++;
           if (m_score % 8 == 0) m_period = (m_period - PSTEP < PMIN) ? PMIN : m_period - PSTEP;
         end
      3: if (eof) begin m_frames++; if (m_frames == 30) ns = 1; end
      4: if (eof) begin m_frames++; if (m_frames == 180) ns = 0; end
      default: ns = 0;
    endcase
    if (ns != s) m_frames = 0;
    e_bt = 0;
    if (ns == 2 && s != 2) m_ball_next = m_t + old_p;
    else if (ns == 2 && s == 2 && m_t == m_ball_next) begin
      e_bt = 1;
      m_ball_next = m_t + old_p;
    end
    e_pt = 0;
    if (active(ns) && !active(s)) m_pad_next = m_t + PADP;
    else if (active(ns) && active(s) && m_t == m_pad_next) begin
      e_pt = 1;
      m_pad_next = m_t + PADP;
    end
    m_state = ns;
  endtask

  // Inputs only change just after posedge, so at negedge they hold for the next edge.
  always @(negedge clk) begin
    if (rst) m_reset();
    chk("state", int'(state), m_state);
    chk("run", int'(run), int'(m_state == 2));
    chk("ball_reset", int'(ball_reset), int'(m_state != 2));
    chk("game_over", int'(game_over), int'(m_state == 4));
    chk("score", int'(score), m_score);
    chk("lives", int'(lives), m_lives);
    chk("ball_tick", int'(ball_tick), int'(e_bt));
    chk("paddle_tick", int'(paddle_tick), int'(e_pt));
    if (!rst) m_step();
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_eof(input int n);
    repeat (n) begin eof = 1; next(); eof = 0; next(); next(); end
  endtask

  task automatic press_left();
    bl = 1; next(); bl = 0; next();
  endtask

  task automatic hits(input int n);
    repeat (n) begin hit = 1; next(); hit = 0; next(); end
  endtask

  task automatic wait_ball(input int budget);
    int n;
    n = 0;
    while (ball_tick !== 1'b1 && n < budget) begin next(); n++; end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL ball_tick_wait: no tick within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  initial begin
    int e_run, t1;
    rst = 1;
    repeat (3) next();
    rst = 0;
    next();
    chk("reset_state", int'(state), 0);
    chk("reset_ball_reset", int'(ball_reset), 1);
    chk("reset_lives", int'(lives), 3);

    // Start: SERVE appears two edges after the button goes down.
    bl = 1; next();
    chk("press_lat1", int'(state), 0);
    bl = 0; next();
    chk("press_serve", int'(state), 1);
    pulse_eof(59);
    chk("serve_59", int'(state), 1);
    eof = 1; next(); eof = 0;
    e_run = cyc;
    chk("run_entry", int'(run), 1);
    chk("run_ball_reset", int'(ball_reset), 0);

    // Speed-up: first interval stays 20000, then 18000, then floor 6000.
    hits(8);
    chk("score_8", int'(score), 8);
    wait_ball(25000);
    chk("first_tick", cyc - e_run, 20000);
    t1 = cyc;
    hits(56);
    chk("score_64", int'(score), 64);
    wait_ball(25000);
    chk("interval_18000", cyc - t1, 18000);
    t1 = cyc;
    next();
    wait_ball(25000);
    chk("interval_6000", cyc - t1, 6000);

    // Miss, re-serve, score retained.
    miss = 1; next(); miss = 0;
    chk("miss_lives", int'(lives), 2);
    chk("miss_state", int'(state), 3);
    pulse_eof(30);
    chk("reserve_state", int'(state), 1);
    chk("reserve_score", int'(score), 64);
    pulse_eof(60);

    // Simultaneous hit and miss.
    hit = 1; miss = 1; next(); hit = 0; miss = 0;
    chk("both_score", int'(score), 64);
    chk("both_lives", int'(lives), 1);
    pulse_eof(30);
    pulse_eof(60);

    // Game over, ignored press, return to idle, fresh start.
    miss = 1; next(); miss = 0;
    chk("over_state", int'(state), 4);
    chk("over_flag", int'(game_over), 1);
    press_left();
    chk("over_press_ignored", int'(state), 4);
    pulse_eof(179);
    chk("over_179", int'(state), 4);
    pulse_eof(1);
    chk("over_idle", int'(state), 0);
    chk("over_score_held", int'(score), 64);
    chk("over_lives_held", int'(lives), 0);
    press_left();
    chk("restart_score", int'(score), 0);
    chk("restart_lives", int'(lives), 3);

    // Held button does not restart; async reset in RUN.
    rst = 1; next(); rst = 0; next();
    br = 1; next(); next();
    chk("hold_serve", int'(state), 1);
    pulse_eof(60);
    repeat (3) next();
    chk("hold_run", int'(state), 2);
    rst = 1;
    #2;
    chk("async_state", int'(state), 0);
    chk("async_run", int'(run), 0);
    chk("async_ball_reset", int'(ball_reset), 1);
    next(); br = 0; next(); rst = 0; next();

    // Randomized play.
    for (int i = 0; i < 20000; i++) begin
      eof  = ($urandom_range(2) == 0);
      hit  = ($urandom_range(15) == 0);
      miss = ($urandom_range(299) == 0);
      if ($urandom_range(39) == 0) bl = ~bl;
      if ($urandom_range(39) == 0) br = ~br;
      rst  = ($urandom_range(4999) == 0);
      next();
    end
    eof = 0; hit = 0; miss = 0; bl = 0; br = 0; rst = 0;
    repeat (3) next();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
